// File: rtl/collision_pair_scheduler_if.sv
// Signal bundle for collision_pair_scheduler: segment loading, scan control,
// the external collision-checker handshake and the per-scan results.
interface collision_pair_scheduler_if #(
    parameter int IDX_W = 4
);
    logic             in_val;
    logic [7:0]       x1, y1, z1, x2, y2, z2;
    logic             in_rdy;
    logic             start;
    logic             clear;
    logic             chk_req;
    logic [47:0]      chk_a, chk_b;
    logic             chk_ack;
    logic             chk_hit;
    logic             out_val;
    logic [IDX_W-1:0] line_a, line_b;
    logic             busy;
    logic             done;
    logic [7:0]       pair_cnt, hit_cnt;

    modport slave (
        input  in_val, x1, y1, z1, x2, y2, z2, start, clear, chk_ack, chk_hit,
        output in_rdy, chk_req, chk_a, chk_b, out_val, line_a, line_b,
               busy, done, pair_cnt, hit_cnt
    );

    modport master (
        output in_val, x1, y1, z1, x2, y2, z2, start, clear, chk_ack, chk_hit,
        input  in_rdy, chk_req, chk_a, chk_b, out_val, line_a, line_b,
               busy, done, pair_cnt, hit_cnt
    );
endinterface

// File: rtl/collision_pair_scheduler.sv
// Loads up to DEPTH segments, then walks every pair (j>i) through an external
// collision checker and reports hits. Macro COLL_SAME_LAYER_FILTER_EN limits pairs to equal z1.
module collision_pair_scheduler #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    collision_pair_scheduler_if.slave bus
);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SCAN   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_REPORT = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t           state_r, state_nxt_s, adv_state_s;
    logic [CNT_W-1:0] count_r, count_nxt_s;
    logic [CNT_W-1:0] j_r, j_nxt_s, adv_j_s, i_inc_s, j_inc_s;
    logic [IDX_W-1:0] i_r, i_nxt_s, adv_i_s;
    logic [47:0]      buf_r [DEPTH];
    logic [47:0]      seg_j_s, seg_i_s, seg_in_s;
    logic             filter_pass_s, wr_en_s, clr_cnt_s, pair_inc_s, hit_inc_s;
    logic             chk_req_r, out_val_r, done_r, busy_r;
    logic [47:0]      chk_a_r, chk_b_r;
    logic [IDX_W-1:0] line_a_r, line_b_r;
    logic [7:0]       pair_cnt_r, hit_cnt_r;

    function automatic logic [7:0] seg_z1(input logic [47:0] seg);
        return seg[31:24];
    endfunction

    assign seg_in_s = {bus.x1, bus.y1, bus.z1, bus.x2, bus.y2, bus.z2};
    assign seg_j_s  = buf_r[j_r[IDX_W-1:0]];
    assign seg_i_s  = buf_r[i_r];

`ifdef COLL_SAME_LAYER_FILTER_EN
    assign filter_pass_s = (seg_z1(seg_j_s) == seg_z1(seg_i_s));
`else
    assign filter_pass_s = 1'b1;
`endif

    // Next pair in lower-triangle order: i runs 0..j-1, then j moves on.
    always_comb begin
        i_inc_s = {1'b0, i_r} + CNT_W'(1);
        j_inc_s = j_r + CNT_W'(1);
        if (i_inc_s < j_r) begin
            adv_i_s     = i_r + IDX_W'(1);
            adv_j_s     = j_r;
            adv_state_s = ST_SCAN;
        end else begin
            adv_i_s     = '0;
            adv_j_s     = j_inc_s;
            adv_state_s = (j_inc_s == count_r) ? ST_DONE : ST_SCAN;
        end
    end

    // Next-state, index and strobe decode for the scan controller.
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        i_nxt_s     = i_r;
        j_nxt_s     = j_r;
        wr_en_s     = 1'b0;
        clr_cnt_s   = 1'b0;
        pair_inc_s  = 1'b0;
        hit_inc_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.clear) begin
                    count_nxt_s = '0;
                end else if (bus.start) begin
                    if (count_r >= CNT_W'(2)) begin
                        state_nxt_s = ST_SCAN;
                        j_nxt_s     = CNT_W'(1);
                        i_nxt_s     = '0;
                        clr_cnt_s   = 1'b1;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end else if (bus.in_val && (count_r < CNT_W'(DEPTH))) begin
                    wr_en_s     = 1'b1;
                    count_nxt_s = count_r + CNT_W'(1);
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            ST_SCAN: begin
                if (filter_pass_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = adv_state_s;
                    i_nxt_s     = adv_i_s;
                    j_nxt_s     = adv_j_s;
                end
            end
            ST_ISSUE: begin
                if (bus.chk_ack) begin
                    pair_inc_s = 1'b1;
                    if (bus.chk_hit) begin
                        state_nxt_s = ST_REPORT;
                    end else begin
                        state_nxt_s = adv_state_s;
                        i_nxt_s     = adv_i_s;
                        j_nxt_s     = adv_j_s;
                    end
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_REPORT: begin
                hit_inc_s   = 1'b1;
                state_nxt_s = adv_state_s;
                i_nxt_s     = adv_i_s;
                j_nxt_s     = adv_j_s;
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Controller state, fill level and pair indices.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            count_r <= '0;
            i_r     <= '0;
            j_r     <= '0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            i_r     <= i_nxt_s;
            j_r     <= j_nxt_s;
        end
    end

    // Segment storage; contents are kept across scans and reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            buf_r[count_r[IDX_W-1:0]] <= seg_in_s;
        end
    end

    // Registered outputs decoded from the upcoming state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            chk_req_r  <= 1'b0;
            out_val_r  <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            chk_a_r    <= '0;
            chk_b_r    <= '0;
            line_a_r   <= '0;
            line_b_r   <= '0;
            pair_cnt_r <= '0;
            hit_cnt_r  <= '0;
        end else begin
            chk_req_r <= (state_nxt_s == ST_ISSUE);
            out_val_r <= (state_nxt_s == ST_REPORT);
            done_r    <= (state_nxt_s == ST_DONE);
            busy_r    <= (state_nxt_s != ST_IDLE);
            if ((state_r == ST_SCAN) && (state_nxt_s == ST_ISSUE)) begin
                chk_a_r <= seg_j_s;
                chk_b_r <= seg_i_s;
            end
            if ((state_r == ST_ISSUE) && (state_nxt_s == ST_REPORT)) begin
                line_a_r <= j_r[IDX_W-1:0];
                line_b_r <= i_r;
            end
            if (clr_cnt_s) begin
                pair_cnt_r <= '0;
            end else if (pair_inc_s && (pair_cnt_r != 8'd255)) begin
                pair_cnt_r <= pair_cnt_r + 8'd1;
            end
            if (clr_cnt_s) begin
                hit_cnt_r <= '0;
            end else if (hit_inc_s && (hit_cnt_r != 8'd255)) begin
                hit_cnt_r <= hit_cnt_r + 8'd1;
            end
        end
    end

    assign bus.in_rdy   = (state_r == ST_IDLE) && (count_r < CNT_W'(DEPTH)) && !bus.start;
    assign bus.chk_req  = chk_req_r;
    assign bus.chk_a    = chk_a_r;
    assign bus.chk_b    = chk_b_r;
    assign bus.out_val  = out_val_r;
    assign bus.line_a   = line_a_r;
    assign bus.line_b   = line_b_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.pair_cnt = pair_cnt_r;
    assign bus.hit_cnt  = hit_cnt_r;
endmodule

// File: tb/tb_collision_pair_scheduler.sv
// Directed-plus-random bench for collision_pair_scheduler with a pair-list
// reference model and a randomized-latency collision checker.
module tb_collision_pair_scheduler;
    localparam int DEPTH = 16;
    localparam int IDX_W = 4;
`ifdef COLL_SAME_LAYER_FILTER_EN
    localparam bit FILT_EN = 1'b1;
`else
    localparam bit FILT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    collision_pair_scheduler_if #(.IDX_W(IDX_W)) bus ();
    collision_pair_scheduler #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [47:0] model_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit pair_passes(input logic [47:0] a, input logic [47:0] b);
        return !FILT_EN || (a[31:24] == b[31:24]);
    endfunction

    function automatic logic [47:0] rand_seg(input logic [7:0] z);
        logic [47:0] s;
        s[47:32] = 16'($urandom);
        s[31:24] = z;
        s[23:0]  = 24'($urandom);
        return s;
    endfunction

    // called at a falling edge; returns on the next falling edge
    task automatic load_seg(input logic [47:0] seg);
        {bus.x1, bus.y1, bus.z1, bus.x2, bus.y2, bus.z2} = seg;
        bus.in_val = 1'b1;
        #1;
        check("in_rdy on load", bus.in_rdy, model_q.size() < DEPTH);
        if (model_q.size() < DEPTH) model_q.push_back(seg);
        @(negedge clk);
        bus.in_val = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        model_q.delete();
    endtask

    // hit_mode: 0 never, 1 random, 2 only pair (2,0)
    task automatic run_scan(input int hit_mode, input int wmin, input int wmax, input bit with_write);
        int exp_j[$];
        int exp_i[$];
        int hit_j[$];
        int hit_i[$];
        int n, k, wait_left, cyc, done_cnt, exp_hits, npairs;
        bit acking, hit;
        n = model_q.size();
        k = 0; wait_left = -1; cyc = 0; done_cnt = 0; exp_hits = 0; acking = 1'b0;
        for (int j = 1; j < n; j++)
            for (int i = 0; i < j; i++)
                if (pair_passes(model_q[j], model_q[i])) begin
                    exp_j.push_back(j);
                    exp_i.push_back(i);
                end
        npairs = exp_j.size();
        bus.start = 1'b1;
        if (with_write) begin
            {bus.x1, bus.y1, bus.z1, bus.x2, bus.y2, bus.z2} = rand_seg(8'd9);
            bus.in_val = 1'b1;
            #1;
            check("start+write in_rdy", bus.in_rdy, 1'b0);
        end
        @(negedge clk);
        bus.start  = 1'b0;
        bus.in_val = 1'b0;
        while (done_cnt == 0 && cyc < 4000) begin
            cyc++;
            if (bus.out_val) begin
                if (hit_j.size() == 0) check("out_val spurious", bus.out_val, 1'b0);
                else begin
                    check("line_a", bus.line_a, hit_j.pop_front());
                    check("line_b", bus.line_b, hit_i.pop_front());
                end
            end
            if (acking) begin
                bus.chk_ack = 1'b0;
                bus.chk_hit = 1'b0;
                acking = 1'b0;
            end else if (wait_left >= 0 && !bus.chk_req) begin
                check("chk_req held", bus.chk_req, 1'b1);
                wait_left = -1;
            end else if (bus.chk_req) begin
                if (wait_left < 0) begin
                    if (k < npairs) begin
                        check("chk_a", bus.chk_a, model_q[exp_j[k]]);
                        check("chk_b", bus.chk_b, model_q[exp_i[k]]);
                    end else check("chk_req extra", bus.chk_req, 1'b0);
                    wait_left = $urandom_range(wmax, wmin);
                end
                if (wait_left == 0) begin
                    hit = 1'b0;
                    if (k < npairs) begin
                        check("chk_a stable", bus.chk_a, model_q[exp_j[k]]);
                        check("chk_b stable", bus.chk_b, model_q[exp_i[k]]);
                        case (hit_mode)
                            1: hit = ($urandom_range(1, 0) == 1);
                            2: hit = (exp_j[k] == 2) && (exp_i[k] == 0);
                            default: hit = 1'b0;
                        endcase
                        if (hit) begin
                            hit_j.push_back(exp_j[k]);
                            hit_i.push_back(exp_i[k]);
                            exp_hits++;
                        end
                    end
                    bus.chk_ack = 1'b1;
                    bus.chk_hit = hit;
                    acking = 1'b1;
                    wait_left = -1;
                    k++;
                end else wait_left--;
            end
            if (bus.done) done_cnt++;
            else @(negedge clk);
        end
        check("done seen", done_cnt, 1);
        check("pairs issued", k, npairs);
        check("hits outstanding", hit_j.size(), 0);
        check("pair_cnt", bus.pair_cnt, (npairs > 255) ? 255 : npairs);
        check("hit_cnt", bus.hit_cnt, exp_hits);
        check("busy at done", bus.busy, 1'b1);
        @(negedge clk);
        check("done one pulse", bus.done, 1'b0);
        check("idle after done", bus.busy, 1'b0);
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        bus.in_val = 1'b0; bus.start = 1'b0; bus.clear = 1'b0;
        bus.chk_ack = 1'b0; bus.chk_hit = 1'b0;
        {bus.x1, bus.y1, bus.z1, bus.x2, bus.y2, bus.z2} = 48'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst chk_req", bus.chk_req, 1'b0);
        check("rst out_val", bus.out_val, 1'b0);
        check("rst done", bus.done, 1'b0);
        check("rst busy", bus.busy, 1'b0);
        check("rst pair_cnt", bus.pair_cnt, 8'd0);
        check("rst hit_cnt", bus.hit_cnt, 8'd0);
        check("rst lines", {bus.line_a, bus.line_b}, 8'd0);
        check("rst chk_a", bus.chk_a, 48'd0);
        check("rst chk_b", bus.chk_b, 48'd0);
        check("rst in_rdy", bus.in_rdy, 1'b1);

        // three same-layer segments, ack after two cycles, hit only on (2,0)
        for (int s = 0; s < 3; s++) load_seg(rand_seg(8'd5));
        run_scan(2, 2, 2, 1'b0);
        check("r044 pair_cnt", bus.pair_cnt, 8'd3);
        check("r044 hit_cnt", bus.hit_cnt, 8'd1);

        // layers 1,2,1,3
        do_clear();
        load_seg(rand_seg(8'd1)); load_seg(rand_seg(8'd2));
        load_seg(rand_seg(8'd1)); load_seg(rand_seg(8'd3));
        run_scan(1, 0, 3, 1'b0);
        check("r045 pair_cnt", bus.pair_cnt, FILT_EN ? 8'd1 : 8'd6);
        run_scan(1, 0, 2, 1'b0);

        // random layers and hits
        do_clear();
        for (int s = 0; s < 7; s++) load_seg(rand_seg(8'($urandom_range(2, 0))));
        run_scan(1, 0, 3, 1'b0);

        // full buffer plus one extra write
        do_clear();
        for (int s = 0; s < 17; s++) load_seg(rand_seg(8'd7));
        check("full in_rdy", bus.in_rdy, 1'b0);
        run_scan(0, 0, 1, 1'b0);
        check("r046 pair_cnt", bus.pair_cnt, 8'd120);
        check("r046 hit_cnt", bus.hit_cnt, 8'd0);

        // single segment: straight to done
        do_clear();
        load_seg(rand_seg(8'd4));
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("r047 done", bus.done, 1'b1);
        check("r047 busy", bus.busy, 1'b1);
        check("r047 chk_req", bus.chk_req, 1'b0);
        @(negedge clk);
        check("r047 done drop", bus.done, 1'b0);
        check("r047 busy drop", bus.busy, 1'b0);

        // start together with a write at count=2
        do_clear();
        load_seg(rand_seg(8'd6)); load_seg(rand_seg(8'd6));
        run_scan(1, 0, 2, 1'b1);
        check("r049 pair_cnt", bus.pair_cnt, 8'd1);

        // reset while a request waits for ack
        do_clear();
        for (int s = 0; s < 3; s++) load_seg(rand_seg(8'd8));
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.chk_req && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("r048 chk_req seen", bus.chk_req, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_q.delete();
        check("r048 chk_req", bus.chk_req, 1'b0);
        check("r048 busy", bus.busy, 1'b0);
        check("r048 done", bus.done, 1'b0);
        bus.chk_ack = 1'b1;
        bus.chk_hit = 1'b1;
        @(negedge clk);
        bus.chk_ack = 1'b0;
        bus.chk_hit = 1'b0;
        @(negedge clk);
        check("r048 late ack out_val", bus.out_val, 1'b0);
        check("r048 late ack done", bus.done, 1'b0);
        check("r048 late ack busy", bus.busy, 1'b0);
        check("r048 pair_cnt", bus.pair_cnt, 8'd0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("r048 empty done", bus.done, 1'b1);
        check("r048 empty chk_req", bus.chk_req, 1'b0);
        @(negedge clk);
        check("r048 empty idle", bus.busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/collision_pair_scheduler.md
COLLISION_PAIR_SCHEDULER -- requirements
Module: collision_pair_scheduler

Interface
REQ-001 Parameter: DEPTH, 16, segment buffer entries (power of 2, 4..64).
REQ-002 Parameter: IDX_W, 4, index width, equal to log2(DEPTH).
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 in_val  in  1  segment write strobe; accepted when in_rdy=1.
REQ-007 x1, y1, z1, x2, y2, z2  in  8 each  segment endpoints, unsigned.
REQ-008 in_rdy  out  1  buffer accepts a write: state IDLE, count<DEPTH, start=0.
REQ-009 start  in  1  begin a pairwise scan of the loaded buffer.
REQ-010 clear  in  1  empties the buffer; honoured only in IDLE.
REQ-011 chk_req  out  1  request to the external collision checker.
REQ-012 chk_a, chk_b  out  48 each  packed segments {x1,y1,z1,x2,y2,z2}, x1 in the MSBs.
REQ-013 chk_ack  in  1  checker accepts the request and returns its result.
REQ-014 chk_hit  in  1  checker result; valid only when chk_ack=1.
REQ-015 out_val  out  1  one-cycle pulse for each colliding pair.
REQ-016 line_a, line_b  out  IDX_W each  indices of the colliding pair; line_a>line_b.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 done  out  1  one-cycle pulse at the end of a scan.
REQ-019 pair_cnt, hit_cnt  out  8 each  pairs issued / hits in the last scan; both saturate at 255.

Function
REQ-020 States: IDLE, SCAN, ISSUE, REPORT, DONE.
REQ-021 IDLE write: in_val&in_rdy stores the segment at index count; count increments at the next edge.
REQ-022 Full buffer: in_val is ignored and the buffer and count are unchanged.
REQ-023 Simultaneous start and in_val: start wins and the write is dropped (in_rdy=0).
REQ-024 clear in IDLE: count is set to 0 at the next edge; clear outside IDLE is ignored; clear has priority over in_val and start.
REQ-025 start in IDLE with count>=2: go to SCAN with j=1, i=0; clear pair_cnt and hit_cnt.
REQ-026 start in IDLE with count<2: go to DONE; no chk_req is issued.
REQ-027 start outside IDLE is ignored.
REQ-028 SCAN takes one cycle to evaluate pair (j,i); if the filter passes, go to ISSUE, otherwise advance.
REQ-029 Advance: if i+1<j then i++; else j++ and i=0; when the new j equals count, go to DONE; otherwise return to SCAN.
REQ-030 ISSUE: chk_req=1, chk_a=buffer[j], chk_b=buffer[i], all held stable until chk_ack is sampled high; pair_cnt increments on ack.
REQ-031 chk_ack=1 with chk_hit=1: go to REPORT. Next cycle: out_val=1, line_a=j, line_b=i, hit_cnt increments, then advance.
REQ-032 chk_ack=1 with chk_hit=0: advance directly; no out_val.
REQ-033 chk_ack outside ISSUE is ignored.
REQ-034 DONE: done=1 for one cycle, then IDLE. Buffer contents and count are retained, so a rescan is possible.
REQ-035 Latency: a filtered-out pair costs 1 cycle; an issued pair costs 1 + ack wait (at least 1 cycle), plus 1 cycle on a hit.
REQ-036 line_a, line_b, chk_a and chk_b hold their last values when not qualified.

Reset
REQ-037 Reset result: state=IDLE, count=0, i=0, j=0.
REQ-038 Outputs cleared by reset: chk_req, out_val, done, busy, pair_cnt, hit_cnt, line_a, line_b, chk_a and chk_b are all 0.
REQ-039 Reset mid-scan: chk_req drops at the same edge; the scan is abandoned with no done pulse.
REQ-040 Buffer RAM contents are not required to reset.

Configuration
REQ-041 Macro COLL_SAME_LAYER_FILTER_EN controls the SCAN filter.
REQ-042 Defined: the filter passes only if buffer[j].z1 == buffer[i].z1 (same print layer).
REQ-043 Undefined: every pair passes, giving count*(count-1)/2 requests.

Verification
REQ-044 Load 3 segments, all with z1=5; checker acks after 2 cycles with hit only for pair (2,0) -> pairs issued in order (1,0),(2,0),(2,1); one out_val with line_a=2, line_b=0; pair_cnt=3, hit_cnt=1; done pulses once.
REQ-045 Filter enabled, load z1 values 1,2,1,3 -> only pair (2,0) is issued; pair_cnt=1. Filter disabled with the same load -> pair_cnt=6.
REQ-046 Load 16 segments, then a 17th in_val -> in_rdy=0 and count stays 16. start with the checker always acking without hit -> pair_cnt=120, hit_cnt=0.
REQ-047 Load 1 segment, then start -> done on the following cycle, chk_req never asserted, busy high for 1 cycle.
REQ-048 Assert reset while chk_req=1 is awaiting ack -> next cycle chk_req=0, busy=0, count=0, no done; a later chk_ack is ignored.
REQ-049 Assert start and in_val in the same IDLE cycle with count=2 -> the write is dropped and the scan covers only pair (1,0).
